// File: rtl/a2_lane_gearbox_4to8.sv
// a2_lane_gearbox_4to8: packs pairs of 4-lane fp32 words into 8-lane words
// behind a 2-entry ready/valid FIFO, with sticky overflow and pop counter.
//
// Ports:
//   clk_78_125           sole clock, rising edge
//   rstn                 asynchronous active-low reset
//   din_valid, a2_0..3   4-lane input word (a2_0 oldest)
//   din_ready            input accepted this cycle when din_valid=1
//   clear                synchronous flush of partial half and FIFO
//   dout_valid, d_0..7   FIFO head (d_0 oldest lane)
//   dout_ready           downstream pops the head
//   overflow             sticky: word dropped while din_ready=0
//   word_cnt             wrapping count of popped 8-lane words
module a2_lane_gearbox_4to8 #(
   parameter int LANE_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk_78_125,
   input  logic              rstn,
   input  logic              din_valid,
   input  logic [LANE_W-1:0] a2_0,
   input  logic [LANE_W-1:0] a2_1,
   input  logic [LANE_W-1:0] a2_2,
   input  logic [LANE_W-1:0] a2_3,
   input  logic              clear,
   output logic              din_ready,
   output logic              dout_valid,
   input  logic              dout_ready,
   output logic [LANE_W-1:0] d_0,
   output logic [LANE_W-1:0] d_1,
   output logic [LANE_W-1:0] d_2,
   output logic [LANE_W-1:0] d_3,
   output logic [LANE_W-1:0] d_4,
   output logic [LANE_W-1:0] d_5,
   output logic [LANE_W-1:0] d_6,
   output logic [LANE_W-1:0] d_7,
   output logic              overflow,
   output logic [CNT_W-1:0]  word_cnt
);

   localparam int HW = 4 * LANE_W;
   localparam int FW = 8 * LANE_W;

   logic          r_ph;
   logic [HW-1:0] r_lo;
   logic [1:0]    r_cnt;
   logic [FW-1:0] r_head;
   logic [FW-1:0] r_tail;
   logic          r_ovf;
   logic [CNT_W-1:0] r_wcnt;

   logic          w_pop;
   logic          w_rdy;
   logic          w_acc;
   logic          w_push;
   logic [HW-1:0] w_in;
   logic [FW-1:0] w_pack;

   assign w_in   = {a2_3, a2_2, a2_1, a2_0};
   assign w_pack = {w_in, r_lo};

   // dout_valid comes only from the count register, never from dout_ready
   assign dout_valid = (r_cnt != 2'd0);
   assign w_pop      = dout_valid & dout_ready;
   // Low half never needs FIFO space; high half needs a slot or a pop
   assign w_rdy      = ~r_ph | (r_cnt < 2'd2) | w_pop;
   assign w_acc      = din_valid & w_rdy;
   assign w_push     = w_acc & r_ph;

   always_ff @(posedge clk_78_125 or negedge rstn) begin
      if (!rstn) begin
         r_ph   <= 1'b0;
         r_lo   <= '0;
         r_cnt  <= 2'd0;
         r_head <= '0;
         r_tail <= '0;
         r_ovf  <= 1'b0;
         r_wcnt <= '0;
      end else if (clear) begin
         r_ph  <= 1'b0;
         r_cnt <= 2'd0;
         r_ovf <= 1'b0;
      end else begin
         if (din_valid && !w_rdy)
            r_ovf <= 1'b1;
         if (w_pop)
            r_wcnt <= r_wcnt + CNT_W'(1);
         if (w_acc && !r_ph) begin
            r_lo <= w_in;
            r_ph <= 1'b1;
         end
         if (w_push)
            r_ph <= 1'b0;
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + 2'd1;
            2'b01:   r_cnt <= r_cnt - 2'd1;
            default: r_cnt <= r_cnt;
         endcase
         // Head advances from tail on a pop at full; a push lands in
         // the head when the FIFO is (or is becoming) a single entry
         if (w_pop && r_cnt == 2'd2)
            r_head <= r_tail;
         else if (w_push && (r_cnt == 2'd0 || w_pop))
            r_head <= w_pack;
         if (w_push && (r_cnt == 2'd2 || (r_cnt == 2'd1 && !w_pop)))
            r_tail <= w_pack;
      end
   end

   assign din_ready = w_rdy;
   assign overflow  = r_ovf;
   assign word_cnt  = r_wcnt;

   assign d_0 = r_head[0*LANE_W +: LANE_W];
   assign d_1 = r_head[1*LANE_W +: LANE_W];
   assign d_2 = r_head[2*LANE_W +: LANE_W];
   assign d_3 = r_head[3*LANE_W +: LANE_W];
   assign d_4 = r_head[4*LANE_W +: LANE_W];
   assign d_5 = r_head[5*LANE_W +: LANE_W];
   assign d_6 = r_head[6*LANE_W +: LANE_W];
   assign d_7 = r_head[7*LANE_W +: LANE_W];

endmodule

// File: tb/tb_a2_lane_gearbox_4to8.sv
// Self-checking bench for a2_lane_gearbox_4to8: queue-based reference
// model checked every cycle, plus literal checks on directed scenarios.
module tb_a2_lane_gearbox_4to8;

   logic        clk_78_125;
   logic        rstn;
   logic        din_valid;
   logic [31:0] a2_0, a2_1, a2_2, a2_3;
   logic        clear;
   logic        din_ready;
   logic        dout_valid;
   logic        dout_ready;
   logic [31:0] d_0, d_1, d_2, d_3, d_4, d_5, d_6, d_7;
   logic        overflow;
   logic [15:0] word_cnt;

   a2_lane_gearbox_4to8 #(.LANE_W(32), .CNT_W(16)) dut (
      .clk_78_125(clk_78_125),
      .rstn(rstn),
      .din_valid(din_valid),
      .a2_0(a2_0),
      .a2_1(a2_1),
      .a2_2(a2_2),
      .a2_3(a2_3),
      .clear(clear),
      .din_ready(din_ready),
      .dout_valid(dout_valid),
      .dout_ready(dout_ready),
      .d_0(d_0), .d_1(d_1), .d_2(d_2), .d_3(d_3),
      .d_4(d_4), .d_5(d_5), .d_6(d_6), .d_7(d_7),
      .overflow(overflow),
      .word_cnt(word_cnt)
   );

   initial clk_78_125 = 1'b0;
   always #5 clk_78_125 = ~clk_78_125;

   wire [255:0] dw = {d_7, d_6, d_5, d_4, d_3, d_2, d_1, d_0};

   int checks = 0;
   int errors = 0;

   // Reference model: list of pending 8-lane words plus the half state
   logic [255:0] q[$];
   bit           m_hi;
   logic [127:0] m_lo;
   bit           m_ovf;
   logic [15:0]  m_wc;

   localparam logic [31:0] L1 = 32'h3f800000;
   localparam logic [31:0] L2 = 32'h40000000;
   localparam logic [31:0] L3 = 32'h40400000;
   localparam logic [31:0] L4 = 32'h40800000;
   localparam logic [31:0] L5 = 32'h40a00000;
   localparam logic [31:0] L6 = 32'h40c00000;
   localparam logic [31:0] L7 = 32'h40e00000;
   localparam logic [31:0] L8 = 32'h41000000;

   task automatic chk(input string nm, input logic [255:0] act,
                      input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
      end
   endtask

   function automatic bit m_rdy();
      return !m_hi || q.size() < 2 || (q.size() > 0 && dout_ready);
   endfunction

   task automatic compare();
      chk("din_ready", 256'(din_ready), 256'(m_rdy()));
      chk("dout_valid", 256'(dout_valid), 256'(q.size() > 0));
      if (q.size() > 0)
         chk("d_word", dw, q[0]);
      chk("overflow", 256'(overflow), 256'(m_ovf));
      chk("word_cnt", 256'(word_cnt), 256'(m_wc));
   endtask

   task automatic model_step();
      bit rdy, pop, acc;
      logic [127:0] w;
      w   = {a2_3, a2_2, a2_1, a2_0};
      rdy = m_rdy();
      if (clear) begin
         m_hi  = 0;
         m_ovf = 0;
         q.delete();
      end else begin
         pop = q.size() > 0 && dout_ready;
         acc = din_valid && rdy;
         if (din_valid && !rdy) m_ovf = 1;
         if (pop) begin
            void'(q.pop_front());
            m_wc = m_wc + 16'd1;
         end
         if (acc) begin
            if (!m_hi) begin
               m_lo = w;
               m_hi = 1;
            end else begin
               q.push_back({w, m_lo});
               m_hi = 0;
            end
         end
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_hi  = 0;
      m_lo  = '0;
      m_ovf = 0;
      m_wc  = '0;
   endtask

   // One clock: drive, compare before the edge, advance the model
   task automatic step(input bit v, input logic [127:0] w,
                       input bit clr, input bit rdy);
      din_valid  = v;
      {a2_3, a2_2, a2_1, a2_0} = w;
      clear      = clr;
      dout_ready = rdy;
      @(negedge clk_78_125);
      compare();
      model_step();
      @(posedge clk_78_125);
      #1;
   endtask

   task automatic do_reset();
      din_valid  = 0;
      clear      = 0;
      dout_ready = 0;
      {a2_3, a2_2, a2_1, a2_0} = '0;
      rstn = 0;
      #2;
      model_reset();
      compare();
      chk("rst_d", dw, 256'h0);
      @(posedge clk_78_125);
      #1;
      rstn = 1;
   endtask

   function automatic logic [127:0] rw();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   logic [127:0] A, B;

   initial begin
      rstn       = 0;
      din_valid  = 0;
      clear      = 0;
      dout_ready = 0;
      {a2_3, a2_2, a2_1, a2_0} = '0;
      model_reset();

      // Basic pack
      do_reset();
      chk("rst_rdy", 256'(din_ready), 256'd1);
      step(1, {L4, L3, L2, L1}, 0, 0);
      chk("basic_vld_mid", 256'(dout_valid), 256'd0);
      step(1, {L8, L7, L6, L5}, 0, 0);
      chk("basic_vld", 256'(dout_valid), 256'd1);
      chk("basic_d", dw, {L8, L7, L6, L5, L4, L3, L2, L1});
      step(0, '0, 0, 1);
      chk("basic_wc", 256'(word_cnt), 256'd1);
      chk("basic_empty", 256'(dout_valid), 256'd0);

      // Gapped input
      do_reset();
      A = rw();
      B = rw();
      step(1, A, 0, 0);
      for (int i = 0; i < 5; i++) step(0, rw(), 0, 0);
      chk("gap_novld", 256'(dout_valid), 256'd0);
      step(1, B, 0, 0);
      chk("gap_d", dw, {B, A});

      // Backpressure: 6 words with dout_ready low
      do_reset();
      for (int i = 0; i < 6; i++) step(1, rw(), 0, 0);
      chk("bp_ovf", 256'(overflow), 256'd1);
      chk("bp_rdy", 256'(din_ready), 256'd0);
      step(0, '0, 0, 1);
      step(0, '0, 0, 1);
      chk("bp_wc", 256'(word_cnt), 256'd2);
      step(0, '0, 0, 0);

      // Push and pop together while full
      do_reset();
      for (int i = 0; i < 5; i++) step(1, rw(), 0, 0);
      step(1, rw(), 0, 1);
      for (int i = 0; i < 3; i++) step(0, '0, 0, 1);
      chk("pp_wc", 256'(word_cnt), 256'd3);

      // Clear mid-pair
      do_reset();
      step(1, rw(), 0, 0);
      step(1, rw(), 1, 0);
      chk("clr_vld", 256'(dout_valid), 256'd0);
      chk("clr_ovf", 256'(overflow), 256'd0);
      A = rw();
      B = rw();
      step(1, A, 0, 0);
      step(1, B, 0, 0);
      chk("clr_pair", dw, {B, A});
      step(0, '0, 0, 1);

      // Asynchronous reset with one queued word and a pending low half
      for (int i = 0; i < 3; i++) step(1, rw(), 0, 0);
      step(0, '0, 0, 0);
      #2;
      rstn = 0;
      #1;
      chk("arst_vld", 256'(dout_valid), 256'd0);
      chk("arst_d", dw, 256'h0);
      chk("arst_wc", 256'(word_cnt), 256'd0);
      chk("arst_rdy", 256'(din_ready), 256'd1);
      model_reset();
      @(posedge clk_78_125);
      #1;
      rstn = 1;

      // Randomized traffic
      for (int i = 0; i < 3000; i++)
         step($urandom_range(0, 9) < 6, rw(),
              $urandom_range(0, 99) < 3, $urandom_range(0, 1) == 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
